data_mem_responder: RTL

- Responder side of the memory-stage data-memory request interface.
- The memory stage initiates read or write requests, either 16-bit or 32-bit (selected by the en32 control bit). This block accepts each request, holds the pipeline via a busy/stall line for the configured latency, performs one or two 16-bit word accesses, and returns read data with a one-cycle valid pulse.
- Sits between the alu/mem pipeline buffer outputs and the mem/wb buffer.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_array.sv | 18 +
 rtl/data_mem_responder.sv | 119 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the memory-stage data-memory responder.
package dmem_pkg;
  localparam int DMEM_WORD_W = 16;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACC_LO,
    ACC_HI,
    RESP
  } dmem_state_e;
endpackage

// File: rtl/dmem_array.sv
// Single-port 2^ADDR_W x 16 data RAM: synchronous write, combinational read.
module dmem_array import dmem_pkg::*; #(
  parameter int ADDR_W = 11
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [DMEM_WORD_W-1:0] i_wdata,
  output logic [DMEM_WORD_W-1:0] o_rdata
);
  logic [DMEM_WORD_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage data-memory responder: stalls for LATENCY cycles, then one or two 16-bit
// word accesses. Optional macro DMEM_PROTECT_EN rejects out-of-range / wrapping requests.
module data_mem_responder import dmem_pkg::*; #(
  parameter int ADDR_W  = 11,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic        i_en32,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_wrData,
  output logic [31:0] o_rdData,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_err
);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_e            r_state;
  logic [3:0]             r_wait;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_en32;
  logic                   r_write;
  logic [DMEM_DATA_W-1:0] r_wrData;
  logic [DMEM_DATA_W-1:0] r_rdData;
  logic                   r_valid;
  logic                   r_err;

  logic                   w_req_one;
  logic                   w_req_both;
  logic                   w_reject;
  logic                   w_accept;
  logic                   w_we;
  logic [ADDR_W-1:0]      w_addr;
  logic [DMEM_WORD_W-1:0] w_wdata;
  logic [DMEM_WORD_W-1:0] w_rdata;

  assign w_req_one  = i_memRead ^ i_memWrite;
  assign w_req_both = i_memRead & i_memWrite;

`ifdef DMEM_PROTECT_EN
  logic w_bad_addr;
  assign w_bad_addr = ((i_addr >> ADDR_W) != '0) ||
                      (i_en32 && (i_addr[ADDR_W-1:0] == '1));
  assign w_reject   = w_req_both | (w_req_one & w_bad_addr);
`else
  logic w_unused_hi;
  assign w_unused_hi = ^i_addr[15:ADDR_W];
  assign w_reject    = w_req_both;
`endif

  assign w_accept = (r_state == IDLE) & w_req_one & ~w_reject;

  // High word wraps within the array (all-ones pairs with word 0).
  assign w_addr  = (r_state == ACC_HI) ? r_addr + ADDR_W'(1) : r_addr;
  assign w_wdata = (r_state == ACC_HI) ? r_wrData[31:16] : r_wrData[15:0];
  assign w_we    = ~rst & r_write & ((r_state == ACC_LO) | (r_state == ACC_HI));

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wait   <= '0;
      r_rdData <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_err <= w_reject;
          if (w_accept) begin
            r_addr   <= i_addr[ADDR_W-1:0];
            r_en32   <= i_en32;
            r_write  <= i_memWrite;
            r_wrData <= i_wrData;
            if (LATENCY == 0) begin
              r_state <= ACC_LO;
            end else begin
              r_state <= WAIT;
              r_wait  <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (r_wait == '0) r_state <= ACC_LO;
          else r_wait <= r_wait - 4'd1;
        end
        ACC_LO: begin
          if (!r_write) r_rdData <= {{DMEM_WORD_W{1'b0}}, w_rdata};
          r_state <= r_en32 ? ACC_HI : RESP;
          r_valid <= ~r_en32;
        end
        ACC_HI: begin
          if (!r_write) r_rdData[31:16] <= w_rdata;
          r_state <= RESP;
          r_valid <= 1'b1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rdData = r_rdData;
  assign o_valid  = r_valid;
  assign o_busy   = (r_state != IDLE);
  assign o_err    = r_err;
endmodule
